// File: rtl/fifo_sched_pkg.sv
// Shared types for the packet-FIFO write scheduler: FSM states, field widths, packet struct.
package fifo_sched_pkg;
  localparam int SRC_W  = 8;
  localparam int DST_W  = 8;
  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DST_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } pkt_t;
endpackage

// File: rtl/fifo_wr_sched_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo NREQ.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);
  logic          found;
  int            j;
  logic [PW-1:0] jp;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    jp    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      jp = PW'(j);
      if (!found && req_i[jp]) begin
        found     = 1'b1;
        gnt_o[jp] = 1'b1;
        idx_o     = jp;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_sched.sv
// Round-robin write scheduler for the packet FIFO with credit-based occupancy tracking
// and a post-reset FIFO reset sequence; one registered write per accept.
module fifo_wr_sched
  import fifo_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*SRC_W-1:0]      req_src,
  input  logic [NREQ*DST_W-1:0]      req_dst,
  input  logic [NREQ*DATA_W-1:0]     req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       fifo_rstp,
  output logic                       fifo_writep,
  output logic [SRC_W-1:0]           fifo_src_in,
  output logic [DST_W-1:0]           fifo_dst_in,
  output logic [DATA_W-1:0]          fifo_data_in,
  input  logic                       fifo_readp,
  input  logic                       fifo_emptyp,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       ready_run
);
  localparam int PW = $clog2(NREQ);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_idx;
  logic [NREQ-1:0] win_gnt;
  logic [OW-1:0]   occ_q, occ_d;
  logic            wr_q;
  pkt_t            pkt_q, pkt_d;
  logic            grant, rd;

  rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  // Credit check uses the registered count only, so a same-cycle read cannot unblock a grant.
  assign grant     = (state_q == ST_RUN) && en && (|req_valid) && (occ_q < OW'(DEPTH));
  assign rd        = fifo_readp && !fifo_emptyp;
  assign req_ready = grant ? win_gnt : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == CW'(RST_CYCLES - 1)) state_d = ST_RUN;
      else                              cnt_d   = cnt_q + 1'b1;
    end

    ptr_d = ptr_q;
    pkt_d = pkt_q;
    if (grant) begin
      ptr_d      = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      pkt_d.src  = req_src [int'(win_idx)*SRC_W  +: SRC_W];
      pkt_d.dst  = req_dst [int'(win_idx)*DST_W  +: DST_W];
      pkt_d.data = req_data[int'(win_idx)*DATA_W +: DATA_W];
    end

    occ_d = occ_q;
    if (grant && !rd)      occ_d = occ_q + 1'b1;
    else if (!grant && rd) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      occ_q   <= '0;
      wr_q    <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
      wr_q    <= grant;
      pkt_q   <= pkt_d;
    end
  end

  assign fifo_rstp    = (state_q == ST_INIT);
  assign ready_run    = (state_q == ST_RUN);
  assign fifo_writep  = wr_q;
  assign fifo_src_in  = pkt_q.src;
  assign fifo_dst_in  = pkt_q.dst;
  assign fifo_data_in = pkt_q.data;
  assign occupancy    = occ_q;
endmodule
